// File: rtl/acq_sequencer.sv
// Acquisition/readout sequencer for a chain of SPIROC-class ASICs: acquire, convert, read each
// chip in turn under a watchdog, and arbitrate slow-control / HV configuration against data taking.
module acq_sequencer #(
    parameter int unsigned N_CHIP     = 2,
    parameter int unsigned CONV_LOW   = 4,
    parameter int unsigned CONV_WAIT  = 200,
    parameter int unsigned RD_TIMEOUT = 40000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              soft_rst,
    input  logic              acquisition,
    input  logic              chipsat,
    input  logic              sc_req,
    input  logic              sc_done,
    input  logic              hv_config_en,
    input  logic              hv_config_done,
    input  logic [N_CHIP-1:0] end_readout,
    output logic              idle,
    output logic              acq,
    output logic              conv,
    output logic [N_CHIP-1:0] read,
    output logic              sc,
    output logic              hv_config,
    output logic [2:0]        chip_idx,
    output logic [N_CHIP-1:0] timeout_flags,
    output logic              error
);

    localparam logic [15:0] ConvLowLast  = 16'(CONV_LOW - 1);
    // Wait phase spans CONV_WAIT+1 cycles so read[0] rises CONV_LOW+CONV_WAIT+1 after acq falls.
    localparam logic [15:0] ConvWaitLast = 16'(CONV_WAIT);
    localparam logic [15:0] RdLast       = 16'(RD_TIMEOUT - 1);
    localparam logic [2:0]  LastChip     = 3'(N_CHIP - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSc,
        StHv,
        StAcq,
        StConv,
        StConvWait,
        StRead,
        StReadNext
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [2:0]        chip_idx_q, chip_idx_d;
    logic [N_CHIP-1:0] flags_q, flags_d;
    logic              error_q, error_d;
    logic              sc_pend_q, sc_pend_d;
    logic              hv_pend_q, hv_pend_d;

    logic [N_CHIP-1:0] chip_sel;
    logic              end_sel;
    logic              sc_any;
    logic              hv_any;

    always_comb begin
        chip_sel = '0;
        for (int i = 0; i < N_CHIP; i++) begin
            chip_sel[i] = (chip_idx_q == 3'(i));
        end
    end

    // Only the chip currently selected may end its readout.
    assign end_sel = |(end_readout & chip_sel);
    assign sc_any  = sc_pend_q | sc_req;
    assign hv_any  = hv_pend_q | hv_config_en;

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        chip_idx_d = chip_idx_q;
        flags_d    = flags_q;
        error_d    = 1'b0;
        sc_pend_d  = sc_any;
        hv_pend_d  = hv_any;

        unique case (state_q)
            StIdle: begin
                if (sc_any) begin
                    state_d   = StSc;
                    sc_pend_d = 1'b0;
                end else if (hv_any) begin
                    state_d   = StHv;
                    hv_pend_d = 1'b0;
                end else if (acquisition) begin
                    state_d    = StAcq;
                    flags_d    = '0;
                    chip_idx_d = '0;
                end
            end

            StSc: begin
                if (sc_done) begin
                    state_d = StIdle;
                end
            end

            StHv: begin
                if (hv_config_done) begin
                    state_d = StIdle;
                end
            end

            StAcq: begin
                // Chips hold partial data either way, so conversion always follows.
                if (chipsat || !acquisition) begin
                    state_d = StConv;
                end
            end

            StConv: begin
                if (cnt_q == ConvLowLast) begin
                    state_d = StConvWait;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            StConvWait: begin
                if (cnt_q == ConvWaitLast) begin
                    state_d    = StRead;
                    chip_idx_d = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            StRead: begin
                if (end_sel) begin
                    state_d = StReadNext;
                end else if (cnt_q == RdLast) begin
                    state_d = StReadNext;
                    flags_d = flags_q | chip_sel;
                    error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            StReadNext: begin
                if (chip_idx_q != LastChip) begin
                    state_d    = StRead;
                    chip_idx_d = chip_idx_q + 3'd1;
                end else if (sc_any || hv_any) begin
                    state_d = StIdle;
                end else if (acquisition) begin
                    state_d = StAcq;
                end else begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            chip_idx_q <= '0;
            flags_q    <= '0;
            error_q    <= 1'b0;
            sc_pend_q  <= 1'b0;
            hv_pend_q  <= 1'b0;
        end else if (soft_rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            chip_idx_q <= '0;
            flags_q    <= '0;
            error_q    <= 1'b0;
            sc_pend_q  <= 1'b0;
            hv_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            chip_idx_q <= chip_idx_d;
            flags_q    <= flags_d;
            error_q    <= error_d;
            sc_pend_q  <= sc_pend_d;
            hv_pend_q  <= hv_pend_d;
        end
    end

    assign idle          = (state_q == StIdle);
    assign acq           = (state_q == StAcq);
    assign conv          = (state_q != StConv);
    assign read          = (state_q == StRead) ? chip_sel : '0;
    assign sc            = (state_q == StSc);
    assign hv_config     = (state_q == StHv);
    assign chip_idx      = chip_idx_q;
    assign timeout_flags = flags_q;
    assign error         = error_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Self-checking bench for acq_sequencer: directed scenarios plus randomized readout lengths,
// checked against event times computed from the sequencing rules.
module tb_acq_sequencer;

    localparam int NC = 2;
    localparam int CL = 4;
    localparam int CW = 10;
    localparam int RT = 100;

    logic          clk;
    logic          rst_n;
    logic          soft_rst;
    logic          acquisition;
    logic          chipsat;
    logic          sc_req;
    logic          sc_done;
    logic          hv_config_en;
    logic          hv_config_done;
    logic [NC-1:0] end_readout;
    logic          idle;
    logic          acq;
    logic          conv;
    logic [NC-1:0] read;
    logic          sc;
    logic          hv_config;
    logic [2:0]    chip_idx;
    logic [NC-1:0] timeout_flags;
    logic          error;

    acq_sequencer #(
        .N_CHIP     (NC),
        .CONV_LOW   (CL),
        .CONV_WAIT  (CW),
        .RD_TIMEOUT (RT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .soft_rst       (soft_rst),
        .acquisition    (acquisition),
        .chipsat        (chipsat),
        .sc_req         (sc_req),
        .sc_done        (sc_done),
        .hv_config_en   (hv_config_en),
        .hv_config_done (hv_config_done),
        .end_readout    (end_readout),
        .idle           (idle),
        .acq            (acq),
        .conv           (conv),
        .read           (read),
        .sc             (sc),
        .hv_config      (hv_config),
        .chip_idx       (chip_idx),
        .timeout_flags  (timeout_flags),
        .error          (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;
    int cyc;

    // Measurements filled by run_seq.
    int            rd_len [NC];
    int            t_start, t_acq_rise, t_acq_fall, t_conv_rise, conv_low, t_idle;
    int            t_rise [NC];
    int            t_fall [NC];
    int            err_cnt, err_at_fall, onehot_bad, sc_hv_bad;
    logic [NC-1:0] flags_end;
    bit            bound_hit;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One full acquisition run from IDLE; chip i ends readout after rd_len[i] cycles of read high.
    task automatic run_seq(input int acq_cycles, input bit use_chipsat, input bit noise);
        int            hi [NC];
        int            acq_high;
        bit            prev_acq, prev_conv, done;
        logic [NC-1:0] prev_rd;
        for (int i = 0; i < NC; i++) begin
            hi[i] = 0;
            t_rise[i] = -1;
            t_fall[i] = -1;
        end
        t_acq_rise = -1; t_acq_fall = -1; t_conv_rise = -1; t_idle = -1;
        conv_low = 0; err_cnt = 0; err_at_fall = 0; onehot_bad = 0; sc_hv_bad = 0;
        flags_end = '0; acq_high = 0; done = 0;
        t_start = cyc;
        acquisition = 1'b1;
        chipsat = 1'b0;
        end_readout = '0;
        prev_acq = acq; prev_conv = conv; prev_rd = read;
        for (int k = 0; k < 3000 && !done; k++) begin
            step();
            if (acq && !prev_acq) t_acq_rise = cyc;
            if (!acq && prev_acq) t_acq_fall = cyc;
            if (!conv) conv_low++;
            if (conv && !prev_conv) t_conv_rise = cyc;
            for (int i = 0; i < NC; i++) begin
                if (read[i] && !prev_rd[i]) t_rise[i] = cyc;
                if (!read[i] && prev_rd[i]) t_fall[i] = cyc;
            end
            if ($countones(read) > 1) onehot_bad++;
            if (sc || hv_config) sc_hv_bad++;
            if (error) begin
                err_cnt++;
                if ((prev_rd & ~read) != '0) err_at_fall++;
            end
            if (idle && t_acq_fall >= 0) begin
                done = 1;
                t_idle = cyc;
                flags_end = timeout_flags;
            end
            chipsat = 1'b0;
            if (acq) begin
                acq_high++;
                if (acq_high == acq_cycles) begin
                    if (use_chipsat) chipsat = 1'b1;
                    else acquisition = 1'b0;
                end
            end
            if (t_acq_fall >= 0) acquisition = 1'b0;
            for (int i = 0; i < NC; i++) begin
                if (read[i]) begin
                    hi[i]++;
                    end_readout[i] = (hi[i] == rd_len[i]);
                end else begin
                    end_readout[i] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                end
            end
            prev_acq = acq; prev_conv = conv; prev_rd = read;
        end
        bound_hit = !done;
        end_readout = '0;
        acquisition = 1'b0;
        chipsat = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle); end
        n_tests++; if (acq !== 1'b0) begin n_fail++; $display("FAIL reset_acq: got %b want 0", acq); end
        n_tests++; if (conv !== 1'b1) begin n_fail++; $display("FAIL reset_conv: got %b want 1", conv); end
        n_tests++; if (read !== '0) begin n_fail++; $display("FAIL reset_read: got %b want 0", read); end
        n_tests++; if (sc !== 1'b0 || hv_config !== 1'b0) begin
            n_fail++; $display("FAIL reset_sc_hv: got %b%b want 00", sc, hv_config);
        end
        n_tests++; if (chip_idx !== 3'd0) begin n_fail++; $display("FAIL reset_chip_idx: got %0d want 0", chip_idx); end
        n_tests++; if (timeout_flags !== '0 || error !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags_error: got %b/%b want 0/0", timeout_flags, error);
        end
    endtask

    task automatic test_nominal();
        rd_len[0] = 30;
        rd_len[1] = 20;
        run_seq(50, 1'b1, 1'b0);
        n_tests++; if (bound_hit) begin n_fail++; $display("FAIL nom_bound: got timeout want idle"); end
        n_tests++; if (t_acq_rise - t_start !== 1) begin
            n_fail++; $display("FAIL nom_acq_latency: got %0d want 1", t_acq_rise - t_start);
        end
        n_tests++; if (t_acq_fall - t_acq_rise !== 50) begin
            n_fail++; $display("FAIL nom_acq_len: got %0d want 50", t_acq_fall - t_acq_rise);
        end
        n_tests++; if (conv_low !== CL) begin n_fail++; $display("FAIL nom_conv_low: got %0d want %0d", conv_low, CL); end
        n_tests++; if (t_conv_rise - t_acq_fall !== CL) begin
            n_fail++; $display("FAIL nom_conv_rise: got %0d want %0d", t_conv_rise - t_acq_fall, CL);
        end
        n_tests++; if (t_rise[0] - t_acq_fall !== 15) begin
            n_fail++; $display("FAIL nom_read0_rise: got %0d want 15", t_rise[0] - t_acq_fall);
        end
        n_tests++; if (t_fall[0] - t_rise[0] !== 30) begin
            n_fail++; $display("FAIL nom_read0_len: got %0d want 30", t_fall[0] - t_rise[0]);
        end
        n_tests++; if (t_rise[1] - t_fall[0] !== 1) begin
            n_fail++; $display("FAIL nom_gap: got %0d want 1", t_rise[1] - t_fall[0]);
        end
        n_tests++; if (t_fall[1] - t_rise[1] !== 20) begin
            n_fail++; $display("FAIL nom_read1_len: got %0d want 20", t_fall[1] - t_rise[1]);
        end
        n_tests++; if (t_idle - t_fall[1] !== 1) begin
            n_fail++; $display("FAIL nom_idle: got %0d want 1", t_idle - t_fall[1]);
        end
        n_tests++; if (err_cnt !== 0 || flags_end !== '0) begin
            n_fail++; $display("FAIL nom_no_error: got err=%0d flags=%b want 0/00", err_cnt, flags_end);
        end
        n_tests++; if (onehot_bad !== 0 || sc_hv_bad !== 0) begin
            n_fail++; $display("FAIL nom_outputs: got onehot_bad=%0d sc_hv_bad=%0d want 0/0", onehot_bad, sc_hv_bad);
        end
    endtask

    task automatic test_timeout();
        rd_len[0] = 100000;
        rd_len[1] = 20;
        run_seq(10, 1'b1, 1'b0);
        n_tests++; if (bound_hit) begin n_fail++; $display("FAIL to_bound: got timeout want idle"); end
        n_tests++; if (t_fall[0] - t_rise[0] !== RT) begin
            n_fail++; $display("FAIL to_read0_len: got %0d want %0d", t_fall[0] - t_rise[0], RT);
        end
        n_tests++; if (err_cnt !== 1 || err_at_fall !== 1) begin
            n_fail++; $display("FAIL to_error: got cnt=%0d at_fall=%0d want 1/1", err_cnt, err_at_fall);
        end
        n_tests++; if (flags_end !== 2'b01) begin n_fail++; $display("FAIL to_flags: got %b want 01", flags_end); end
        n_tests++; if (t_rise[1] - t_fall[0] !== 1 || t_fall[1] - t_rise[1] !== 20) begin
            n_fail++; $display("FAIL to_chip1: got gap=%0d len=%0d want 1/20",
                               t_rise[1] - t_fall[0], t_fall[1] - t_rise[1]);
        end
    endtask

    task automatic test_coincide();
        rd_len[0] = RT;
        rd_len[1] = 15;
        run_seq(5, 1'b0, 1'b0);
        n_tests++; if (bound_hit) begin n_fail++; $display("FAIL co_bound: got timeout want idle"); end
        n_tests++; if (err_cnt !== 0 || flags_end !== '0) begin
            n_fail++; $display("FAIL co_no_error: got err=%0d flags=%b want 0/00", err_cnt, flags_end);
        end
        n_tests++; if (t_fall[0] - t_rise[0] !== RT || t_rise[1] - t_fall[0] !== 1) begin
            n_fail++; $display("FAIL co_advance: got len=%0d gap=%0d want %0d/1",
                               t_fall[0] - t_rise[0], t_rise[1] - t_fall[0], RT);
        end
    endtask

    task automatic test_random();
        int            acq_cycles;
        bit            use_cs;
        int            exp_err, exp_hi, got_hi;
        logic [NC-1:0] exp_flags;
        for (int it = 0; it < 8; it++) begin
            acq_cycles = $urandom_range(1, 40);
            use_cs = 1'($urandom_range(0, 1));
            exp_err = 0;
            exp_flags = '0;
            for (int i = 0; i < NC; i++) begin
                rd_len[i] = $urandom_range(1, 115);
                if (rd_len[i] > RT) begin
                    exp_err++;
                    exp_flags[i] = 1'b1;
                end
            end
            run_seq(acq_cycles, use_cs, 1'b1);
            n_tests++; if (bound_hit) begin n_fail++; $display("FAIL rnd%0d_bound: got timeout want idle", it); end
            n_tests++; if (t_acq_fall - t_acq_rise !== acq_cycles) begin
                n_fail++; $display("FAIL rnd%0d_acq_len: got %0d want %0d", it, t_acq_fall - t_acq_rise, acq_cycles);
            end
            n_tests++; if (t_rise[0] - t_acq_fall !== CL + CW + 1 || conv_low !== CL) begin
                n_fail++; $display("FAIL rnd%0d_conv: got rise=%0d low=%0d want %0d/%0d",
                                   it, t_rise[0] - t_acq_fall, conv_low, CL + CW + 1, CL);
            end
            for (int i = 0; i < NC; i++) begin
                exp_hi = (rd_len[i] > RT) ? RT : rd_len[i];
                got_hi = t_fall[i] - t_rise[i];
                n_tests++; if (got_hi !== exp_hi) begin
                    n_fail++; $display("FAIL rnd%0d_read%0d_len: got %0d want %0d", it, i, got_hi, exp_hi);
                end
            end
            n_tests++; if (t_rise[1] - t_fall[0] !== 1) begin
                n_fail++; $display("FAIL rnd%0d_gap: got %0d want 1", it, t_rise[1] - t_fall[0]);
            end
            n_tests++; if (err_cnt !== exp_err || err_at_fall !== exp_err || flags_end !== exp_flags) begin
                n_fail++; $display("FAIL rnd%0d_watchdog: got err=%0d at_fall=%0d flags=%b want %0d/%0d/%b",
                                   it, err_cnt, err_at_fall, flags_end, exp_err, exp_err, exp_flags);
            end
            n_tests++; if (onehot_bad !== 0 || t_idle - t_fall[NC-1] !== 1) begin
                n_fail++; $display("FAIL rnd%0d_end: got onehot_bad=%0d idle_delay=%0d want 0/1",
                                   it, onehot_bad, t_idle - t_fall[NC-1]);
            end
        end
    endtask

    task automatic test_sc_during_read();
        int            hi [NC];
        bit            found;
        int            t_last_fall, t_sc, t_idle_seen, acq_bad;
        logic [NC-1:0] prev_rd;
        acquisition = 1'b1;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin step(); found = acq; end
        chipsat = 1'b1;
        step();
        chipsat = 1'b0;
        found = 0;
        for (int k = 0; k < 60 && !found; k++) begin step(); found = read[0]; end
        n_tests++; if (!found) begin n_fail++; $display("FAIL scr_read0: got no read want read[0]"); end
        for (int i = 0; i < NC; i++) hi[i] = 0;
        t_last_fall = -1; t_sc = -1; t_idle_seen = -1;
        prev_rd = read;
        for (int k = 0; k < 400 && t_sc < 0; k++) begin
            sc_req = (k == 2);
            for (int i = 0; i < NC; i++) begin
                if (read[i]) begin
                    hi[i]++;
                    end_readout[i] = (hi[i] == 10);
                end else begin
                    end_readout[i] = 1'b0;
                end
            end
            step();
            if (!read[NC-1] && prev_rd[NC-1]) t_last_fall = cyc;
            if (idle && t_last_fall >= 0 && t_idle_seen < 0) t_idle_seen = cyc;
            if (sc) t_sc = cyc;
            prev_rd = read;
        end
        sc_req = 1'b0;
        end_readout = '0;
        n_tests++; if (t_sc < 0 || t_last_fall < 0 || t_sc - t_last_fall !== 2) begin
            n_fail++; $display("FAIL scr_sc_rise: got sc=%0d last_fall=%0d want sc 2 after fall", t_sc, t_last_fall);
        end
        n_tests++; if (t_idle_seen - t_last_fall !== 1) begin
            n_fail++; $display("FAIL scr_idle: got %0d want 1", t_idle_seen - t_last_fall);
        end
        acq_bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (acq || !sc) acq_bad++;
            step();
        end
        n_tests++; if (acq_bad !== 0) begin n_fail++; $display("FAIL scr_hold: got %0d bad cycles want 0", acq_bad); end
        sc_done = 1'b1;
        step();
        sc_done = 1'b0;
        n_tests++; if (sc !== 1'b0 || idle !== 1'b1) begin
            n_fail++; $display("FAIL scr_done: got sc=%b idle=%b want 0/1", sc, idle);
        end
        step();
        n_tests++; if (acq !== 1'b1) begin n_fail++; $display("FAIL scr_reacq: got %b want 1", acq); end
        acquisition = 1'b0;
        soft_rst = 1'b1;
        step();
        soft_rst = 1'b0;
        step();
    endtask

    task automatic test_sc_hv_same_cycle();
        sc_req = 1'b1;
        hv_config_en = 1'b1;
        step();
        sc_req = 1'b0;
        hv_config_en = 1'b0;
        n_tests++; if (sc !== 1'b1 || hv_config !== 1'b0) begin
            n_fail++; $display("FAIL schv_sc_first: got sc=%b hv=%b want 1/0", sc, hv_config);
        end
        step(); step();
        sc_done = 1'b1;
        step();
        sc_done = 1'b0;
        n_tests++; if (sc !== 1'b0 || idle !== 1'b1 || hv_config !== 1'b0) begin
            n_fail++; $display("FAIL schv_idle: got sc=%b idle=%b hv=%b want 0/1/0", sc, idle, hv_config);
        end
        step();
        n_tests++; if (hv_config !== 1'b1 || idle !== 1'b0) begin
            n_fail++; $display("FAIL schv_hv: got hv=%b idle=%b want 1/0", hv_config, idle);
        end
        step(); step();
        n_tests++; if (hv_config !== 1'b1) begin n_fail++; $display("FAIL schv_hv_hold: got %b want 1", hv_config); end
        hv_config_done = 1'b1;
        step();
        hv_config_done = 1'b0;
        n_tests++; if (hv_config !== 1'b0 || idle !== 1'b1) begin
            n_fail++; $display("FAIL schv_hv_done: got hv=%b idle=%b want 0/1", hv_config, idle);
        end
        step();
        n_tests++; if (idle !== 1'b1 || sc !== 1'b0 || hv_config !== 1'b0) begin
            n_fail++; $display("FAIL schv_settle: got idle=%b sc=%b hv=%b want 1/0/0", idle, sc, hv_config);
        end
    endtask

    task automatic test_soft_rst();
        int hi0;
        bit found;
        acquisition = 1'b1;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin step(); found = acq; end
        acquisition = 1'b0;
        found = 0;
        hi0 = 0;
        for (int k = 0; k < 400 && !found; k++) begin
            step();
            if (read[0]) begin
                hi0++;
                end_readout[0] = (hi0 == 5);
            end else begin
                end_readout[0] = 1'b0;
            end
            found = read[1];
        end
        end_readout = '0;
        n_tests++; if (!found) begin n_fail++; $display("FAIL srst_reach_read1: got no read[1] want read[1]"); end
        step(); step();
        n_tests++; if (chip_idx !== 3'd1 || read !== 2'b10) begin
            n_fail++; $display("FAIL srst_pre: got idx=%0d read=%b want 1/10", chip_idx, read);
        end
        soft_rst = 1'b1;
        step();
        soft_rst = 1'b0;
        n_tests++; if (read !== '0 || idle !== 1'b1 || chip_idx !== 3'd0 || conv !== 1'b1 || acq !== 1'b0) begin
            n_fail++; $display("FAIL srst_values: got read=%b idle=%b idx=%0d conv=%b acq=%b want 00/1/0/1/0",
                               read, idle, chip_idx, conv, acq);
        end
        // Asynchronous reset while in ACQ, checked before any further clock edge.
        acquisition = 1'b1;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin step(); found = acq; end
        rst_n = 1'b0;
        #2;
        n_tests++; if (!found || acq !== 1'b0 || idle !== 1'b1 || conv !== 1'b1 || read !== '0 || chip_idx !== 3'd0) begin
            n_fail++; $display("FAIL rstn_async: got seen=%b acq=%b idle=%b conv=%b read=%b idx=%0d want 1/0/1/1/00/0",
                               found, acq, idle, conv, read, chip_idx);
        end
        acquisition = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_tests++; if (idle !== 1'b1 || acq !== 1'b0) begin
            n_fail++; $display("FAIL rstn_release: got idle=%b acq=%b want 1/0", idle, acq);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        cyc = 0;
        rst_n = 1'b0;
        soft_rst = 1'b0;
        acquisition = 1'b0;
        chipsat = 1'b0;
        sc_req = 1'b0;
        sc_done = 1'b0;
        hv_config_en = 1'b0;
        hv_config_done = 1'b0;
        end_readout = '0;
        test_reset();
        test_nominal();
        test_timeout();
        test_coincide();
        test_random();
        test_sc_during_read();
        test_sc_hv_same_cycle();
        test_soft_rst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
